// File: rtl/dp_memory_wrapper.sv
// dp_memory_wrapper: 4096 x 32 simple dual-port RAM (distributed style).
// It has one synchronous write port (a/d/we) and one asynchronous read
// port (dpra/dpo). A reset-started sweep writes zero to every word, so
// the contents are known after each reset. While the sweep runs, dpo
// reads 0 and external writes are dropped.
module dp_memory_wrapper #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d,
  input  logic              we,
  input  logic [ADDR_W-1:0] dpra,
  output logic [DATA_W-1:0] dpo,
  output logic              init_busy
);

  // Storage and the clear engine start from a known power-up state:
  // all words zero, the engine idle, and the counter at zero.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic              busy        = 1'b0;
  logic [ADDR_W-1:0] clr_cnt     = '0;

  // Write-port mux. The clear engine has the port while busy; otherwise
  // the external port owns it. Nothing is written while rst is held.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Select who drives the single write port this cycle
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave a value held (no latch)
    wr_en   = 1'b0;
    wr_addr = a;
    wr_data = d;
    if (!rst) begin
      if (busy) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = '0;
      end else begin
        wr_en   = we;
      end
    end
  end

  // Clear-engine control: reset (re)starts the sweep from address 0, and
  // busy drops on the edge that clears the last word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values
    if (rst) begin
      busy    <= 1'b1;
      clr_cnt <= '0;
    end else if (busy) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
        busy <= 1'b0;
      end
    end
  end

  // Array write port: one word per edge, with no byte enables
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; the clear engine zeroes it, which keeps it mappable to RAM
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read is combinational and has no write bypass. The clear engine
  // forces the output to zero while it runs.
  assign dpo       = busy ? '0 : mem[dpra];
  assign init_busy = busy;

endmodule

// File: tb/tb_dp_memory_wrapper.sv
// Self-checking bench for dp_memory_wrapper. It applies a table of
// directed vectors, then hand-written sequences for read-during-write,
// the reset clear sweep, and reset during a sweep.
module tb_dp_memory_wrapper;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4096;
  localparam int LIMIT  = 5000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] a = '0;
  logic [DATA_W-1:0] d = '0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] dpra = '0;
  logic [DATA_W-1:0] dpo;
  logic              init_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  dp_memory_wrapper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .d         (d),
    .we        (we),
    .dpra      (dpra),
    .dpo       (dpo),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] dpra;
    logic [DATA_W-1:0] exp_dpo;
    logic              exp_busy;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] exp);
    @(negedge clk);
    we   = 1'b0;
    dpra = addr;
    #1;
    check(name, dpo, exp);
  endtask

  // Start at a negedge with init_busy high. Count rising edges until
  // init_busy falls or max_cycles is reached. Record any nonzero dpo seen
  // while busy. If inject is set, drive a write to a=7 on cycle 50.
  task automatic run_sweep(input int max_cycles, input bit inject,
                           output int cycles, output bit dpo_bad);
    cycles  = 0;
    dpo_bad = 1'b0;
    while (init_busy === 1'b1 && cycles < max_cycles) begin
      if (dpo !== '0) dpo_bad = 1'b1;
      if (inject && cycles == 50) begin
        we = 1'b1; a = 12'd7; d = 32'h0000_0077;
      end else begin
        we = 1'b0;
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    we = 1'b0;
  endtask

  initial begin
    int cycles;
    bit dpo_bad;

    //           name              we    a       d              dpra    exp_dpo        busy
    vecs[0]  = '{"powerup_rd30",   1'b0, 12'd0,  32'h0,         12'd30,   32'h0,         1'b0};
    vecs[1]  = '{"wr10_pre",       1'b1, 12'd10, 32'hDEADBEEF,  12'd10,   32'h0,         1'b0};
    vecs[2]  = '{"rd10",           1'b1, 12'd20, 32'h12345678,  12'd10,   32'hDEADBEEF,  1'b0};
    vecs[3]  = '{"rd20",           1'b0, 12'd0,  32'h0,         12'd20,   32'h12345678,  1'b0};
    vecs[4]  = '{"rd30",           1'b0, 12'd0,  32'h0,         12'd30,   32'h0,         1'b0};
    vecs[5]  = '{"wr5_1",          1'b1, 12'd5,  32'h1,         12'd5,    32'h0,         1'b0};
    vecs[6]  = '{"rdw5_old",       1'b1, 12'd5,  32'h2,         12'd5,    32'h1,         1'b0};
    vecs[7]  = '{"rd5_new",        1'b0, 12'd0,  32'h0,         12'd5,    32'h2,         1'b0};
    vecs[8]  = '{"wr0_rd1",        1'b1, 12'd0,  32'hFFFFFFFF,  12'd1,    32'h0,         1'b0};
    vecs[9]  = '{"wr4095_rd0",     1'b1, 12'd4095, 32'hA5A5A5A5, 12'd0,   32'hFFFFFFFF,  1'b0};
    vecs[10] = '{"rd4095",         1'b0, 12'd0,  32'h0,         12'd4095, 32'hA5A5A5A5,  1'b0};
    vecs[11] = '{"rd4094",         1'b0, 12'd0,  32'h0,         12'd4094, 32'h0,         1'b0};
    vecs[12] = '{"rd1",            1'b0, 12'd0,  32'h0,         12'd1,    32'h0,         1'b0};

    // Each vector's dpo is checked before its write edge
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      we   = vecs[i].we;
      a    = vecs[i].a;
      d    = vecs[i].d;
      dpra = vecs[i].dpra;
      #1;
      check({vecs[i].name, "_dpo"}, dpo, vecs[i].exp_dpo);
      check({vecs[i].name, "_busy"}, {31'b0, init_busy}, {31'b0, vecs[i].exp_busy});
    end

    // Read-during-write to the same address: old word before the edge,
    // new word right after it
    @(negedge clk);
    we = 1'b1; a = 12'd5; d = 32'h3; dpra = 12'd5;
    #1;
    check("rdw_before_edge", dpo, 32'h2);
    @(posedge clk);
    #1;
    check("rdw_after_edge", dpo, 32'h3);
    @(negedge clk);
    we = 1'b0;

    // Reset clear sweep with a write injected during the sweep
    @(negedge clk);
    rst = 1'b1; dpra = 12'd10;
    @(posedge clk);
    #1;
    check("rst_busy", {31'b0, init_busy}, 32'h1);
    check("rst_dpo_forced", dpo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(LIMIT, 1'b1, cycles, dpo_bad);
    check("sweep_len", cycles, DEPTH);
    check("sweep_dpo_zero", {31'b0, dpo_bad}, 32'h0);
    check("sweep_done_busy", {31'b0, init_busy}, 32'h0);
    read_check("clr_rd0", 12'd0, 32'h0);
    read_check("clr_rd10", 12'd10, 32'h0);
    read_check("clr_rd20", 12'd20, 32'h0);
    read_check("clr_rd4095", 12'd4095, 32'h0);
    read_check("clr_rd7_dropped", 12'd7, 32'h0);
    read_check("clr_rd5", 12'd5, 32'h0);

    // Normal writes work again after the sweep
    @(negedge clk);
    we = 1'b1; a = 12'd7; d = 32'hCAFE0007;
    @(negedge clk);
    we = 1'b0;
    read_check("post_clr_wr7", 12'd7, 32'hCAFE0007);

    // Reset during a sweep restarts it from address 0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_sweep(100, 1'b0, cycles, dpo_bad);
    check("mid_first_len", cycles, 100);
    check("mid_busy_at_100", {31'b0, init_busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy_in_rst", {31'b0, init_busy}, 32'h1);
    rst = 1'b0;
    run_sweep(LIMIT, 1'b0, cycles, dpo_bad);
    check("mid_restart_len", cycles, DEPTH);
    check("mid_dpo_zero", {31'b0, dpo_bad}, 32'h0);
    check("mid_done_busy", {31'b0, init_busy}, 32'h0);
    read_check("mid_rd7", 12'd7, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
